// File: rtl/otter_arb_pkg.sv
// Shared types and constants for the OTTER data-port arbiter.
// Requester ids, FSM states and memory access sizes.
package otter_arb_pkg;

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      RD_DATA
   } arb_state_t;

   typedef logic req_id_t;

   localparam logic [1:0]  SZ_BYTE = 2'd0;
   localparam logic [1:0]  SZ_HALF = 2'd1;
   localparam logic [1:0]  SZ_WORD = 2'd2;

   localparam logic [31:0] IO_BASE = 32'h1100_0000;

endpackage

// File: rtl/otter_arb_pick.sv
// Combinational two-way picker for the data-port arbiter.
// OTTER_ARB_RR_EN selects round-robin; otherwise requester 0 has fixed priority.
module otter_arb_pick
   import otter_arb_pkg::*;
(
   input  logic [1:0] req,
   input  req_id_t    last,
   output logic [1:0] gnt,
   output req_id_t    id
);

`ifndef OTTER_ARB_RR_EN
   logic unused_last;
   assign unused_last = last;
`endif

   always_comb begin
      gnt = 2'b00;
      id  = 1'b0;
`ifdef OTTER_ARB_RR_EN
      // On contention the requester that was not served last time wins.
      if (req == 2'b11) begin
         id = ~last;
      end else if (req[1]) begin
         id = 1'b1;
      end
`else
      if (!req[0] && req[1]) begin
         id = 1'b1;
      end
`endif
      if (req != 2'b00) begin
         gnt = (id == 1'b1) ? 2'b10 : 2'b01;
      end
   end

endmodule

// File: rtl/otter_dport_arbiter.sv
// Sequencer and two-way arbiter for port 2 of OTTER_mem_byte (CPU vs DMA).
// Build option: define OTTER_ARB_RR_EN for round-robin instead of fixed priority.
module otter_dport_arbiter
   import otter_arb_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic              CLK,
   input  logic              RST_N,
   input  logic              R0_REQ,
   input  logic              R0_WE,
   input  logic [ADDR_W-1:0] R0_ADDR,
   input  logic [DATA_W-1:0] R0_DIN,
   input  logic [1:0]        R0_SIZE,
   input  logic              R0_SIGN,
   output logic              R0_GNT,
   output logic              R0_RVALID,
   output logic [DATA_W-1:0] R0_RDATA,
   input  logic              R1_REQ,
   input  logic              R1_WE,
   input  logic [ADDR_W-1:0] R1_ADDR,
   input  logic [DATA_W-1:0] R1_DIN,
   input  logic [1:0]        R1_SIZE,
   input  logic              R1_SIGN,
   output logic              R1_GNT,
   output logic              R1_RVALID,
   output logic [DATA_W-1:0] R1_RDATA,
   output logic [ADDR_W-1:0] MEM_ADDR2,
   output logic [DATA_W-1:0] MEM_DIN2,
   output logic              MEM_WRITE2,
   output logic              MEM_READ2,
   output logic [1:0]        MEM_SIZE,
   output logic              MEM_SIGN,
   input  logic [DATA_W-1:0] MEM_DOUT2
);

   arb_state_t        state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] din_q, din_d;
   logic [1:0]        size_q, size_d;
   logic              sign_q, sign_d;
   logic              write_q, write_d;
   logic              read_q, read_d;
   req_id_t           winner_q, winner_d;
   logic [DATA_W-1:0] r0_rdata_q, r0_rdata_d;
   logic [DATA_W-1:0] r1_rdata_q, r1_rdata_d;
   logic              r0_rvalid_q, r0_rvalid_d;
   logic              r1_rvalid_q, r1_rvalid_d;

   logic              grant_en;
   logic [1:0]        pick_req;
   logic [1:0]        pick_gnt;
   req_id_t           pick_id;
   req_id_t           last;

   // Grants only leave IDLE, and never while reset is held.
   assign grant_en = (state_q == IDLE) && RST_N;
   assign pick_req = {R1_REQ, R0_REQ} & {2{grant_en}};

   otter_arb_pick u_pick (
      .req  (pick_req),
      .last (last),
      .gnt  (pick_gnt),
      .id   (pick_id)
   );

   assign R0_GNT = pick_gnt[0];
   assign R1_GNT = pick_gnt[1];

`ifdef OTTER_ARB_RR_EN
   req_id_t last_q, last_d;

   always_comb begin
      last_d = last_q;
      if (pick_gnt != 2'b00) begin
         last_d = pick_id;
      end
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         last_q <= 1'b1;
      end else begin
         last_q <= last_d;
      end
   end

   assign last = last_q;
`else
   assign last = 1'b1;
`endif

   always_comb begin
      state_d     = state_q;
      addr_d      = addr_q;
      din_d       = din_q;
      size_d      = size_q;
      sign_d      = sign_q;
      winner_d    = winner_q;
      write_d     = 1'b0;
      read_d      = 1'b0;
      r0_rdata_d  = r0_rdata_q;
      r1_rdata_d  = r1_rdata_q;
      r0_rvalid_d = 1'b0;
      r1_rvalid_d = 1'b0;
      case (state_q)
         IDLE: begin
            if (pick_gnt != 2'b00) begin
               winner_d = pick_id;
               state_d  = ISSUE;
               if (pick_id == 1'b0) begin
                  addr_d  = R0_ADDR;
                  din_d   = R0_DIN;
                  size_d  = R0_SIZE;
                  sign_d  = R0_SIGN;
                  write_d = R0_WE;
                  read_d  = !R0_WE;
               end else begin
                  addr_d  = R1_ADDR;
                  din_d   = R1_DIN;
                  size_d  = R1_SIZE;
                  sign_d  = R1_SIGN;
                  write_d = R1_WE;
                  read_d  = !R1_WE;
               end
            end
         end
         ISSUE: begin
            state_d = write_q ? IDLE : RD_DATA;
         end
         RD_DATA: begin
            // Address/size/sign stay put here: memory slices DOUT from them live.
            if (winner_q == 1'b0) begin
               r0_rdata_d  = MEM_DOUT2;
               r0_rvalid_d = 1'b1;
            end else begin
               r1_rdata_d  = MEM_DOUT2;
               r1_rvalid_d = 1'b1;
            end
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q     <= IDLE;
         addr_q      <= '0;
         din_q       <= '0;
         size_q      <= 2'b00;
         sign_q      <= 1'b0;
         write_q     <= 1'b0;
         read_q      <= 1'b0;
         winner_q    <= 1'b0;
         r0_rdata_q  <= '0;
         r1_rdata_q  <= '0;
         r0_rvalid_q <= 1'b0;
         r1_rvalid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         din_q       <= din_d;
         size_q      <= size_d;
         sign_q      <= sign_d;
         write_q     <= write_d;
         read_q      <= read_d;
         winner_q    <= winner_d;
         r0_rdata_q  <= r0_rdata_d;
         r1_rdata_q  <= r1_rdata_d;
         r0_rvalid_q <= r0_rvalid_d;
         r1_rvalid_q <= r1_rvalid_d;
      end
   end

   assign MEM_ADDR2  = addr_q;
   assign MEM_DIN2   = din_q;
   assign MEM_SIZE   = size_q;
   assign MEM_SIGN   = sign_q;
   assign MEM_WRITE2 = write_q;
   assign MEM_READ2  = read_q;
   assign R0_RDATA   = r0_rdata_q;
   assign R1_RDATA   = r1_rdata_q;
   assign R0_RVALID  = r0_rvalid_q;
   assign R1_RVALID  = r1_rvalid_q;

endmodule
